ext_mem_loader: RTL and testbench
=================================

Name: ext_mem_loader

Overview:
- Hardware initiator for the external load/run/readback port of top_control_4. It replaces the bench-driven sequence with synthesizable control.
- Accepts a 16-bit command/data word stream over valid/ready, for example from a UART deframer.
- Drives the IRAM writes for cores 1–4 and the DRAM writes, then runs the processor, then streams a DRAM address window back out.
- Sits between the host link and top_control_4.

Parameters:
- ADDR_W, 9, width of addr_ext.
- DATA_W, 16, instruction/data word width.
- SETUP_CYC, 2, cycles that data/address are held stable before the write strobe rises.
- PULSE_CYC, 4, cycles the write strobe is held high.
- HOLD_CYC, 4, cycles the strobe is low after the pulse, before the address increments.
- READ_LAT, 5, cycles from read_en_ext rising to the point dram_in is sampled.
- RUN_CYC_W, 24, width of the run-length counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  16  command or payload word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  16  readback word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- addr_ext  out  ADDR_W  external address to top_control_4.
- Data_in_ins  out  16  IRAM write data.
- Data_in_dram  out  16  DRAM write data.
- iram_write_ext_1..4  out  1 each  per-core IRAM write strobes.
- dram_write_ext  out  1  DRAM write strobe.
- read_en_ext  out  1  DRAM external read enable.
- dram_in_1  in  16  DRAM read data.
- start  out  1  processor run.
- start_2  out  1  IRAM-load mode.
- start_3  out  1  DRAM-load mode.
- start_4  out  1  readback mode.
- busy  out  1  state is not IDLE.
- cmd_err  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset: every output is 0; addr_ext = 0; run_len = 0; fin_start = 0; fin_end = 0; state IDLE.
  - Reset asserted mid-operation drops all strobes and modes in the same cycle. No partial write completes.
- Command word: [15:13] opcode, [10:9] core select (0..3 selects core 1..4), [8:0] argument.
  - 000 NOP.
  - 001 LOAD_IRAM: arg = word count N.
  - 010 LOAD_DRAM: arg = N.
  - 011 SET_START: fin_start <= arg.
  - 100 SET_END: fin_end <= arg.
  - 101 SET_RUN: run_len <= {arg, 15'b0}, truncated to RUN_CYC_W.
  - 110 RUN.
  - 111 READBACK.
- in_ready = 1 only in IDLE and in LD_WAIT. Handshake is in_valid & in_ready; one word per cycle at most.
- FSM states: IDLE, LD_WAIT, LD_SETUP, LD_PULSE, LD_HOLD, RUN, RB_SETUP, RB_WAIT, RB_OUT.
- IDLE:
  - LOAD with N = 0: no state change; mode stays 0.
  - LOAD with N > 0: addr_ext <= 1; mode (start_2 for IRAM, start_3 for DRAM) rises the next cycle; go to LD_WAIT.
- LD_WAIT: on a payload handshake, latch the word into Data_in_ins or Data_in_dram (only the targeted bus changes); go to LD_SETUP.
- LD_SETUP: held SETUP_CYC cycles, then LD_PULSE.
- LD_PULSE: the selected strobe is high for exactly PULSE_CYC cycles. Only one strobe is ever high at a time. Then LD_HOLD.
- LD_HOLD: HOLD_CYC cycles, then addr_ext += 1 and remaining -= 1.
  - remaining > 0: back to LD_WAIT.
  - remaining = 0: mode drops, go to IDLE.
- Address wrap: addr_ext wraps 511 -> 0 silently. N up to 511 is legal.
- RUN:
  - All modes 0; start = 1 for run_len cycles, then 0; back to IDLE.
  - run_len = 0: start pulses for 1 cycle.
- READBACK with fin_end <= fin_start: no reads; back to IDLE with no output.
- READBACK otherwise:
  - addr_ext <= fin_start; start_4 = 1 for the whole phase.
  - RB_SETUP (1 cycle), then read_en_ext = 1.
  - RB_WAIT: READ_LAT cycles, then capture dram_in_1 into out_data; read_en_ext = 0; out_valid = 1.
  - RB_OUT: hold out_data until out_ready, then addr += 1.
  - Repeats while addr < fin_end. Exactly fin_end - fin_start words are emitted.
  - start_4 drops when the phase finishes.
- Illegal/unused: the core-select field is ignored for non-IRAM opcodes. Opcode NOP keeps cmd_err = 0; cmd_err is reserved and never pulses because all 8 opcodes are defined.
- Mode exclusivity: at most one of start, start_2, start_3, start_4 is high in any cycle.

Decomposition:
- Package ext_loader_pkg: opcode localparams, command field bit positions, FSM state encoding.
- One sub-module, strobe_timer: a loadable down-counter with a done flag, shared by the SETUP/PULSE/HOLD/READ_LAT/RUN waits.

Test Plan:
- LOAD_IRAM core 2, N = 3, words 0x1111/0x2222/0x3333:
  - start_2 high throughout.
  - iram_write_ext_2 pulses 4 cycles wide, three times, at addr 1, 2, 3.
  - Other strobes stay 0; Data_in_ins matches each word.
  - Finishes with addr_ext = 4 and start_2 low.
- LOAD_DRAM N = 2 with in_valid stalls of 7 cycles between words: the FSM waits in LD_WAIT, dram_write_ext stays 0 while waiting, start_3 stays high, writes land at addr 1 and 2.
- SET_RUN arg = 1 then RUN: start high for exactly 32768 cycles, then busy = 0.
- SET_START = 10, SET_END = 13, READBACK with a memory model holding 10 -> 0xA, 11 -> 0xB, 12 -> 0xC, and out_ready low 3 cycles on the 2nd word:
  - Outputs are 0xA, 0xB, 0xC in order.
  - out_data is stable while stalled; no 4th word.
- SET_START = 20, SET_END = 20, READBACK: no read_en_ext, no out_valid, back to IDLE within 2 cycles.
- Reset asserted during LD_PULSE of core 4: iram_write_ext_4, start_2 and addr_ext are 0 immediately; the next command is accepted normally.

Source files
------------

// File: rtl/ext_loader_pkg.sv
// Shared opcodes, command-word field positions and FSM encoding for ext_mem_loader.
package ext_loader_pkg;

    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_LOAD_IRAM = 3'b001;
    localparam logic [2:0] OP_LOAD_DRAM = 3'b010;
    localparam logic [2:0] OP_SET_START = 3'b011;
    localparam logic [2:0] OP_SET_END   = 3'b100;
    localparam logic [2:0] OP_SET_RUN   = 3'b101;
    localparam logic [2:0] OP_RUN       = 3'b110;
    localparam logic [2:0] OP_READBACK  = 3'b111;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int CORE_MSB = 10;
    localparam int CORE_LSB = 9;
    localparam int ARG_MSB  = 8;
    localparam int ARG_LSB  = 0;
    localparam int ARG_W    = ARG_MSB - ARG_LSB + 1;

    typedef enum logic [3:0] {
        IDLE,
        LD_WAIT,
        LD_SETUP,
        LD_PULSE,
        LD_HOLD,
        RUN,
        RB_SETUP,
        RB_WAIT,
        RB_OUT
    } state_t;

endpackage

// File: rtl/ext_mem_loader_strobe_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module strobe_timer #(
    parameter int W = 24
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/ext_mem_loader.sv
// Command-driven initiator for the load/run/readback port of top_control_4.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting command words
// LD_WAIT  | load mode active, waiting for the next payload word
// LD_SETUP | data/address stable before the write strobe
// LD_PULSE | selected write strobe high
// LD_HOLD  | strobe low again, address advances at the end
// RUN      | processor start held for run_len cycles
// RB_SETUP | readback address settles before read enable
// RB_WAIT  | read enable high, waiting out the DRAM read latency
// RB_OUT   | readback word presented until the consumer takes it
module ext_mem_loader
    import ext_loader_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 4,
    parameter int READ_LAT  = 5,
    parameter int RUN_CYC_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] addr_ext,
    output logic [DATA_W-1:0] Data_in_ins,
    output logic [DATA_W-1:0] Data_in_dram,
    output logic              iram_write_ext_1,
    output logic              iram_write_ext_2,
    output logic              iram_write_ext_3,
    output logic              iram_write_ext_4,
    output logic              dram_write_ext,
    output logic              read_en_ext,
    input  logic [DATA_W-1:0] dram_in_1,
    output logic              start,
    output logic              start_2,
    output logic              start_3,
    output logic              start_4,
    output logic              busy,
    output logic              cmd_err
);

    state_t state, next_state;

    logic [2:0]           cmd_op;
    logic [1:0]           cmd_core;
    logic [ARG_W-1:0]     cmd_arg;
    logic                 accept;

    logic [ARG_W-1:0]     remaining;
    logic                 is_dram;
    logic [1:0]           core_sel;
    logic [ADDR_W-1:0]    fin_start;
    logic [ADDR_W-1:0]    fin_end;
    logic [RUN_CYC_W-1:0] run_len;
    logic [ADDR_W:0]      addr_next;

    logic                 timer_load;
    logic [RUN_CYC_W-1:0] timer_val;
    logic                 timer_done;

    assign cmd_op    = in_data[OP_MSB:OP_LSB];
    assign cmd_core  = in_data[CORE_MSB:CORE_LSB];
    assign cmd_arg   = in_data[ARG_MSB:ARG_LSB];
    assign accept    = in_valid & in_ready;
    assign addr_next = {1'b0, addr_ext} + (ADDR_W+1)'(1);

    strobe_timer #(.W(RUN_CYC_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic, handshake ready and timer reloads.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD_IRAM, OP_LOAD_DRAM:
                            if (cmd_arg != '0) next_state = LD_WAIT;
                        OP_RUN: begin
                            next_state = RUN;
                            timer_load = 1'b1;
                            timer_val  = (run_len == '0) ? '0 : run_len - RUN_CYC_W'(1);
                        end
                        OP_READBACK:
                            if (fin_end > fin_start) next_state = RB_SETUP;
                        default: ;
                    endcase
                end
            end
            LD_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = LD_SETUP;
                    timer_load = 1'b1;
                    timer_val  = RUN_CYC_W'(SETUP_CYC - 1);
                end
            end
            LD_SETUP: if (timer_done) begin
                next_state = LD_PULSE;
                timer_load = 1'b1;
                timer_val  = RUN_CYC_W'(PULSE_CYC - 1);
            end
            LD_PULSE: if (timer_done) begin
                next_state = LD_HOLD;
                timer_load = 1'b1;
                timer_val  = RUN_CYC_W'(HOLD_CYC - 1);
            end
            LD_HOLD: if (timer_done)
                next_state = (remaining == ARG_W'(1)) ? IDLE : LD_WAIT;
            RUN: if (timer_done)
                next_state = IDLE;
            RB_SETUP: begin
                next_state = RB_WAIT;
                timer_load = 1'b1;
                timer_val  = RUN_CYC_W'(READ_LAT - 1);
            end
            RB_WAIT: if (timer_done)
                next_state = RB_OUT;
            RB_OUT: if (out_ready)
                next_state = (addr_next < {1'b0, fin_end}) ? RB_SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address, payload, configuration and readback registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_ext     <= '0;
            Data_in_ins  <= '0;
            Data_in_dram <= '0;
            out_data     <= '0;
            remaining    <= '0;
            is_dram      <= 1'b0;
            core_sel     <= 2'd0;
            fin_start    <= '0;
            fin_end      <= '0;
            run_len      <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_LOAD_IRAM: if (cmd_arg != '0) begin
                            addr_ext  <= ADDR_W'(1);
                            remaining <= cmd_arg;
                            is_dram   <= 1'b0;
                            core_sel  <= cmd_core;
                        end
                        OP_LOAD_DRAM: if (cmd_arg != '0) begin
                            addr_ext  <= ADDR_W'(1);
                            remaining <= cmd_arg;
                            is_dram   <= 1'b1;
                        end
                        OP_SET_START: fin_start <= ADDR_W'(cmd_arg);
                        OP_SET_END:   fin_end   <= ADDR_W'(cmd_arg);
                        OP_SET_RUN:   run_len   <= RUN_CYC_W'({cmd_arg, 15'b0});
                        OP_READBACK:  if (fin_end > fin_start) addr_ext <= fin_start;
                        default: ;
                    endcase
                end
                LD_WAIT: if (accept) begin
                    if (is_dram)
                        Data_in_dram <= in_data;
                    else
                        Data_in_ins  <= in_data;
                end
                LD_HOLD: if (timer_done) begin
                    addr_ext  <= addr_ext + ADDR_W'(1);
                    remaining <= remaining - ARG_W'(1);
                end
                RB_WAIT: if (timer_done) out_data <= dram_in_1;
                RB_OUT:  if (out_ready)  addr_ext <= addr_ext + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign iram_write_ext_1 = (state == LD_PULSE) && !is_dram && (core_sel == 2'd0);
    assign iram_write_ext_2 = (state == LD_PULSE) && !is_dram && (core_sel == 2'd1);
    assign iram_write_ext_3 = (state == LD_PULSE) && !is_dram && (core_sel == 2'd2);
    assign iram_write_ext_4 = (state == LD_PULSE) && !is_dram && (core_sel == 2'd3);
    assign dram_write_ext   = (state == LD_PULSE) &&  is_dram;

    assign start       = (state == RUN);
    assign start_2     = (state inside {LD_WAIT, LD_SETUP, LD_PULSE, LD_HOLD}) && !is_dram;
    assign start_3     = (state inside {LD_WAIT, LD_SETUP, LD_PULSE, LD_HOLD}) &&  is_dram;
    assign start_4     = (state inside {RB_SETUP, RB_WAIT, RB_OUT});
    assign read_en_ext = (state == RB_WAIT);
    assign out_valid   = (state == RB_OUT);
    assign busy        = (state != IDLE);
    // Every opcode is defined, so there is nothing to flag.
    assign cmd_err     = 1'b0;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader: loads, run timing, readback and mid-pulse reset.
module tb_ext_mem_loader;

    localparam int READ_LAT = 5;

    logic        clock;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  addr_ext;
    logic [15:0] Data_in_ins;
    logic [15:0] Data_in_dram;
    logic        iram_write_ext_1, iram_write_ext_2, iram_write_ext_3, iram_write_ext_4;
    logic        dram_write_ext;
    logic        read_en_ext;
    logic [15:0] dram_in_1;
    logic        start, start_2, start_3, start_4;
    logic        busy;
    logic        cmd_err;

    int vectors     = 0;
    int miscompares = 0;

    wire [4:0] strobes = {dram_write_ext, iram_write_ext_4, iram_write_ext_3,
                          iram_write_ext_2, iram_write_ext_1};
    wire [3:0] modes   = {start, start_2, start_3, start_4};

    ext_mem_loader dut (
        .clock            (clock),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .addr_ext         (addr_ext),
        .Data_in_ins      (Data_in_ins),
        .Data_in_dram     (Data_in_dram),
        .iram_write_ext_1 (iram_write_ext_1),
        .iram_write_ext_2 (iram_write_ext_2),
        .iram_write_ext_3 (iram_write_ext_3),
        .iram_write_ext_4 (iram_write_ext_4),
        .dram_write_ext   (dram_write_ext),
        .read_en_ext      (read_en_ext),
        .dram_in_1        (dram_in_1),
        .start            (start),
        .start_2          (start_2),
        .start_3          (start_3),
        .start_4          (start_4),
        .busy             (busy),
        .cmd_err          (cmd_err)
    );

    // DRAM content seen by the readback port.
    function automatic logic [15:0] mem_model(input logic [8:0] a);
        case (a)
            9'd10:   return 16'h000A;
            9'd11:   return 16'h000B;
            9'd12:   return 16'h000C;
            default: return 16'hDEAD;
        endcase
    endfunction
    assign dram_in_1 = mem_model(addr_ext);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until the loader takes it.
    task automatic send(input logic [15:0] w);
        int n = 0;
        @(negedge clock);
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("in_ready", in_ready, 1);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    // Walk the 2 setup, 4 pulse and 4 hold cycles of one write.
    task automatic check_write(input logic [8:0] a, input logic [4:0] mask, input logic [3:0] mode);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("wr_strobe", strobes, (i >= 2 && i < 6) ? mask : 5'b0);
            check("wr_mode", modes, mode);
            check("wr_addr", addr_ext, a);
        end
    endtask

    // One readback word: setup, READ_LAT cycles of read enable, then output.
    task automatic rb_word(input logic [8:0] a, input logic [15:0] d, input bit stall);
        @(negedge clock);
        check("rb_setup_addr", addr_ext, a);
        check("rb_setup_ren", {read_en_ext, out_valid}, 2'b00);
        check("rb_mode", modes, 4'b0001);
        for (int i = 0; i < READ_LAT; i++) begin
            @(negedge clock);
            check("rb_wait_ren", {read_en_ext, out_valid}, 2'b10);
        end
        @(negedge clock);
        check("rb_out_valid", {read_en_ext, out_valid}, 2'b01);
        check("rb_out_data", out_data, d);
        if (stall) begin
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("rb_stall_valid", out_valid, 1);
                check("rb_stall_data", out_data, d);
            end
            out_ready = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset     = 1'b1;
        in_data   = 16'h0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state.
        check("rst_strobes", strobes, 0);
        check("rst_modes", modes, 0);
        check("rst_addr", addr_ext, 0);
        check("rst_busy", busy, 0);
        check("rst_outv", {out_valid, read_en_ext, cmd_err}, 0);
        check("rst_data", {Data_in_ins, Data_in_dram}, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        // NOP and zero-length load leave the block idle.
        send(16'h0000);
        @(negedge clock);
        check("nop_busy", busy, 0);
        check("nop_err", cmd_err, 0);
        send(16'h2200);
        @(negedge clock);
        check("n0_busy", busy, 0);
        check("n0_modes", modes, 0);

        // LOAD_IRAM core 2, three words.
        send(16'h2203);
        @(negedge clock);
        check("li_mode", modes, 4'b0100);
        check("li_addr", addr_ext, 1);
        send(16'h1111);
        check_write(9'd1, 5'b00010, 4'b0100);
        check("li_data1", Data_in_ins, 16'h1111);
        send(16'h2222);
        check_write(9'd2, 5'b00010, 4'b0100);
        check("li_data2", Data_in_ins, 16'h2222);
        send(16'h3333);
        check_write(9'd3, 5'b00010, 4'b0100);
        check("li_data3", Data_in_ins, 16'h3333);
        @(negedge clock);
        check("li_end_addr", addr_ext, 4);
        check("li_end_mode", modes, 0);
        check("li_end_busy", busy, 0);

        // LOAD_DRAM N=2 with core bits set (ignored) and a 7-cycle stall.
        send(16'h4602);
        send(16'hBEEF);
        check_write(9'd1, 5'b10000, 4'b0010);
        check("ld_data1", Data_in_dram, 16'hBEEF);
        check("ld_ins_kept", Data_in_ins, 16'h3333);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            check("ld_stall_strobe", strobes, 0);
            check("ld_stall_mode", modes, 4'b0010);
            check("ld_stall_busy", busy, 1);
        end
        send(16'hCAFE);
        check_write(9'd2, 5'b10000, 4'b0010);
        check("ld_data2", Data_in_dram, 16'hCAFE);
        @(negedge clock);
        check("ld_end_addr", addr_ext, 3);
        check("ld_end_busy", busy, 0);

        // SET_RUN 1 -> 32768 run cycles.
        send(16'hA001);
        send(16'hC000);
        cnt = 0;
        @(negedge clock);
        check("run_mode", modes, 4'b1000);
        while (start && cnt < 40000) begin
            cnt++;
            @(negedge clock);
        end
        check("run_len", cnt, 32768);
        check("run_busy", busy, 0);

        // Readback 10..12 with a stall on the second word.
        send(16'h600A);
        send(16'h800D);
        send(16'hE000);
        rb_word(9'd10, 16'h000A, 1'b0);
        rb_word(9'd11, 16'h000B, 1'b1);
        rb_word(9'd12, 16'h000C, 1'b0);
        @(negedge clock);
        check("rb_end_busy", busy, 0);
        check("rb_end_mode", modes, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rb_no_4th", {read_en_ext, out_valid}, 2'b00);
        end

        // Empty window: no reads at all.
        send(16'h6014);
        send(16'h8014);
        send(16'hE000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rb_empty_ren", {read_en_ext, out_valid}, 2'b00);
            check("rb_empty_busy", busy, 0);
            check("rb_empty_mode", modes, 0);
        end

        // Reset during the core 4 write pulse.
        send(16'h2602);
        send(16'h4444);
        repeat (2) @(negedge clock);
        @(negedge clock);
        check("rp_pulse", strobes, 5'b01000);
        #2 reset = 1'b1;
        #1;
        check("rp_strobes", strobes, 0);
        check("rp_modes", modes, 0);
        check("rp_addr", addr_ext, 0);
        check("rp_busy", busy, 0);
        check("rp_data", Data_in_ins, 0);
        @(negedge clock);
        reset = 1'b0;
        send(16'h4001);
        send(16'h5555);
        check_write(9'd1, 5'b10000, 4'b0010);
        check("rp_dram_data", Data_in_dram, 16'h5555);
        @(negedge clock);
        check("rp_end_addr", addr_ext, 2);
        check("rp_end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
